// File: rtl/ibra_valrdy_to_credit.sv
// Valid/ready to credit-based flow-control bridge with a 1-cycle registered output stage.
// Optional macro IBRA_V2C_CREDIT_CHECK_EN builds the sticky credit-overflow detector.
module ibra_valrdy_to_credit #(
  parameter int DATA_WIDTH = 64,
  parameter int CREDITS    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  yummy_in,
  output logic                  credit_err
);

  localparam logic [3:0] CREDITS_C = 4'(CREDITS);

  logic [3:0]            credit_cnt_q, credit_cnt_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  xfer_s;
  logic                  overflow_s;

  // Readiness depends only on the registered count, never on this cycle's inputs.
  assign ready_in   = (credit_cnt_q != 4'd0);
  assign xfer_s     = valid_in & ready_in;
  assign overflow_s = yummy_in & ~xfer_s & (credit_cnt_q == CREDITS_C);

  // Credit counter and output stage next-state.
  always_comb begin
    credit_cnt_d = credit_cnt_q;
    data_out_d   = data_out_q;
    valid_out_d  = 1'b0;
    case ({xfer_s, yummy_in})
      2'b10:   credit_cnt_d = credit_cnt_q - 4'd1;
      2'b01: begin
        if (overflow_s) begin
          credit_cnt_d = credit_cnt_q;
        end else begin
          credit_cnt_d = credit_cnt_q + 4'd1;
        end
      end
      default: credit_cnt_d = credit_cnt_q;
    endcase
    if (xfer_s) begin
      data_out_d  = data_in;
      valid_out_d = 1'b1;
    end else begin
      data_out_d  = data_out_q;
      valid_out_d = 1'b0;
    end
  end

  // Main state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      credit_cnt_q <= CREDITS_C;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
    end else begin
      credit_cnt_q <= credit_cnt_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;

`ifdef IBRA_V2C_CREDIT_CHECK_EN
  logic credit_err_q, credit_err_d;

  // Overflow flag is sticky until reset.
  always_comb begin
    if (overflow_s) begin
      credit_err_d = 1'b1;
    end else begin
      credit_err_d = credit_err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      credit_err_q <= 1'b0;
    end else begin
      credit_err_q <= credit_err_d;
    end
  end

  assign credit_err = credit_err_q;
`else
  assign credit_err = 1'b0;
`endif

endmodule
